// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam logic MASTER_CPU = 1'b0;
   localparam logic MASTER_AUX = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave Avalon-style arbiter: round-robin with a bounded hold count,
// combinational forwarding of the owner's request, sticky read+write error flag.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [3:0]  m0_byteenable,
   input  logic [31:0] m0_writedata,
   output logic [31:0] m0_readdata,
   output logic        m0_waitrequest,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [3:0]  m1_byteenable,
   input  logic [31:0] m1_writedata,
   output logic [31:0] m1_readdata,
   output logic        m1_waitrequest,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byteenable,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata,
   input  logic        s_waitrequest,
   output logic [1:0]  grant,
   output logic        protocol_error
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW:0] MAX_HOLD_W = MAX_HOLD;
   localparam logic [HW:0] CNT_ONE    = 1;

   arb_state_t    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          protocol_error_q, protocol_error_d;

   logic          req0, req1;
   logic          own_id, own_req, own_rd, own_wr, oth_req;
   arb_state_t    oth_state;
   logic          complete, hold_done;
   logic [HW:0]   hold_inc;
   logic [HW-1:0] hold_sat;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   assign own_id    = (state_q == GRANT1) ? MASTER_AUX : MASTER_CPU;
   assign own_req   = own_id ? req1 : req0;
   assign own_rd    = own_id ? m1_read : m0_read;
   assign own_wr    = own_id ? m1_write : m0_write;
   assign oth_req   = own_id ? req0 : req1;
   assign oth_state = own_id ? GRANT0 : GRANT1;

   assign complete  = (state_q != IDLE) && own_req && !s_waitrequest;
   assign hold_inc  = {1'b0, hold_cnt_q} + CNT_ONE;
   assign hold_done = (hold_inc >= MAX_HOLD_W);
   // Saturate so a long solo run cannot wrap and hand the owner extra turns later
   assign hold_sat  = (hold_inc > MAX_HOLD_W) ? hold_cnt_q : hold_inc[HW-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= MASTER_AUX;
         hold_cnt_q       <= '0;
         protocol_error_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         hold_cnt_q       <= hold_cnt_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      hold_cnt_d       = hold_cnt_q;
      protocol_error_d = protocol_error_q;
      unique case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            if (req0 && req1) begin
               state_d = (last_grant_q == MASTER_CPU) ? GRANT1 : GRANT0;
            end else if (req0) begin
               state_d = GRANT0;
            end else if (req1) begin
               state_d = GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            if (own_rd && own_wr) begin
               protocol_error_d = 1'b1;
            end
            if (complete) begin
               hold_cnt_d   = hold_sat;
               last_grant_d = own_id;
            end
            if (complete && hold_done && oth_req) begin
               state_d    = oth_state;
               hold_cnt_d = '0;
            end else if (!own_req && oth_req) begin
               state_d    = oth_state;
               hold_cnt_d = '0;
            end else if (!own_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_byteenable   = '0;
      s_writedata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      grant          = 2'b00;
      case (state_q)
         GRANT0: begin
            s_address      = m0_address;
            s_read         = m0_read & ~m0_write;
            s_write        = m0_write;
            s_byteenable   = m0_byteenable;
            s_writedata    = m0_writedata;
            m0_waitrequest = s_waitrequest;
            grant          = 2'b01;
         end
         GRANT1: begin
            s_address      = m1_address;
            s_read         = m1_read & ~m1_write;
            s_write        = m1_write;
            s_byteenable   = m1_byteenable;
            s_writedata    = m1_writedata;
            m1_waitrequest = s_waitrequest;
            grant          = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_readdata    = s_readdata;
   assign m1_readdata    = s_readdata;
   assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus randomized traffic against an ownership/streak reference model.
module tb_mem_bus_arbiter;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] m0_address = '0, m1_address = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] s_address;
   logic        s_read, s_write;
   logic [3:0]  s_byteenable;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata = '0;
   logic        s_waitrequest = 1'b0;
   logic [1:0]  grant;
   logic        protocol_error;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // Reference model: who owns the slave (-1 = nobody), who last completed, current streak
   int owner = -1;
   int last = 1;
   int streak = 0;
   bit err = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_byteenable(s_byteenable), .s_writedata(s_writedata),
      .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .grant(grant), .protocol_error(protocol_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_model();
      logic [31:0] e_addr, e_wd;
      logic [3:0]  e_be;
      logic        e_rd, e_wr, e_w0, e_w1;
      logic [1:0]  e_gnt;
      e_addr = '0; e_wd = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
      e_w0 = 1'b1; e_w1 = 1'b1; e_gnt = 2'b00;
      if (owner == 0) begin
         e_addr = m0_address; e_wd = m0_writedata; e_be = m0_byteenable;
         e_rd = m0_read && !m0_write; e_wr = m0_write; e_w0 = s_waitrequest; e_gnt = 2'b01;
      end else if (owner == 1) begin
         e_addr = m1_address; e_wd = m1_writedata; e_be = m1_byteenable;
         e_rd = m1_read && !m1_write; e_wr = m1_write; e_w1 = s_waitrequest; e_gnt = 2'b10;
      end
      chk("grant", grant, e_gnt);
      chk("s_address", s_address, e_addr);
      chk("s_writedata", s_writedata, e_wd);
      chk("s_byteenable", s_byteenable, e_be);
      chk("s_read", s_read, e_rd);
      chk("s_write", s_write, e_wr);
      chk("m0_waitrequest", m0_waitrequest, e_w0);
      chk("m1_waitrequest", m1_waitrequest, e_w1);
      chk("readdata", {m0_readdata ^ s_readdata} | {m1_readdata ^ s_readdata}, 32'h0);
      chk("protocol_error", protocol_error, err);
   endtask

   task automatic model_step();
      bit req[2], rd[2], wr[2], done;
      int k, o;
      rd[0] = m0_read; wr[0] = m0_write; rd[1] = m1_read; wr[1] = m1_write;
      req[0] = rd[0] || wr[0]; req[1] = rd[1] || wr[1];
      if (reset) begin
         owner = -1; last = 1; streak = 0; err = 1'b0;
      end else if (owner < 0) begin
         if (req[0] && req[1]) owner = 1 - last;
         else if (req[0]) owner = 0;
         else if (req[1]) owner = 1;
         streak = 0;
      end else begin
         k = owner; o = 1 - k;
         done = req[k] && !s_waitrequest;
         if (rd[k] && wr[k]) err = 1'b1;
         if (done) begin streak++; last = k; end
         if (done && streak >= MAX_HOLD && req[o]) begin owner = o; streak = 0; end
         else if (!req[k] && req[o]) begin owner = o; streak = 0; end
         else if (!req[k]) owner = -1;
      end
   endtask

   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      s_waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      model_step();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int comps;
      bit seen;
      s_readdata = 32'h1234_5678;

      // Reset state
      do_reset();
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_read", s_read, 1'b0);
      chk("rst_s_write", s_write, 1'b0);
      chk("rst_s_address", s_address, 32'h0);
      chk("rst_m0_wait", m0_waitrequest, 1'b1);
      chk("rst_m1_wait", m1_waitrequest, 1'b1);
      chk("rst_perr", protocol_error, 1'b0);

      // Single master, zero wait states
      m0_address = 32'hBFC0_0000; m0_read = 1'b1; m0_byteenable = 4'hF;
      tick();
      #1;
      chk("single_grant", grant, 2'b01);
      chk("single_m0_wait", m0_waitrequest, 1'b0);
      chk("single_m1_wait", m1_waitrequest, 1'b1);
      chk("single_s_read", s_read, 1'b1);
      chk("single_s_addr", s_address, 32'hBFC0_0000);
      chk("single_rdata", m0_readdata, 32'h1234_5678);
      m0_read = 1'b0;
      tick();
      tick();

      // Tie-break right after reset
      do_reset();
      m0_read = 1'b1; m1_read = 1'b1; m1_address = 32'h0000_0040;
      tick();
      #1;
      chk("tie_first", grant, 2'b01);
      tick();
      m0_read = 1'b0;
      #1;
      chk("tie_no_idle", grant, 2'b01);
      tick();
      #1;
      chk("tie_second", grant, 2'b10);
      tick();
      idle_inputs();
      tick();

      // Fairness with bounded hold
      do_reset();
      m0_read = 1'b1; m0_address = 32'h0000_1000;
      tick();
      m1_write = 1'b1; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF;
      m1_address = 32'h0000_2000;
      comps = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (grant == 2'b10) begin seen = 1'b1; break; end
         if (grant == 2'b01 && m0_waitrequest == 1'b0) comps++;
         tick();
      end
      chk("fair_switch", seen, 1'b1);
      chk("fair_m0_count", comps, 4);
      chk("fair_s_write", s_write, 1'b1);
      chk("fair_s_wdata", s_writedata, 32'hDEAD_BEEF);
      chk("fair_s_be", s_byteenable, 4'hF);

      // Slave stall during m1 write while m0 keeps requesting
      s_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_grant", grant, 2'b10);
         chk("stall_s_addr", s_address, 32'h0000_2000);
         chk("stall_no_m0_read", s_read, 1'b0);
         tick();
      end
      s_waitrequest = 1'b0;
      #1;
      chk("stall_done_grant", grant, 2'b10);
      tick();
      m1_write = 1'b0;
      tick();
      tick();

      // Illegal read+write from the owner
      do_reset();
      m0_read = 1'b1; m0_write = 1'b1; m0_writedata = 32'hA5A5_0001;
      tick();
      #1;
      chk("err_s_read", s_read, 1'b0);
      chk("err_s_write", s_write, 1'b1);
      tick();
      chk("err_flag", protocol_error, 1'b1);
      idle_inputs();
      for (int i = 0; i < 3; i++) tick();
      chk("err_sticky", protocol_error, 1'b1);
      do_reset();
      #1;
      chk("err_cleared", protocol_error, 1'b0);

      // Reset aborts a stalled transaction
      m1_read = 1'b1; s_waitrequest = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("abort_grant", grant, 2'b00);
      chk("abort_s_read", s_read, 1'b0);
      chk("abort_s_write", s_write, 1'b0);
      chk("abort_m0_wait", m0_waitrequest, 1'b1);
      chk("abort_m1_wait", m1_waitrequest, 1'b1);
      idle_inputs();
      tick();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) m0_read = ~m0_read;
         if ($urandom_range(0, 3) == 0) m0_write = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) m1_read = ~m1_read;
         if ($urandom_range(0, 3) == 0) m1_write = ($urandom_range(0, 5) == 0);
         m0_address = $urandom; m1_address = $urandom;
         m0_writedata = $urandom; m1_writedata = $urandom;
         m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
         s_readdata = $urandom;
         s_waitrequest = ($urandom_range(0, 2) == 0);
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      idle_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter for the Avalon-style memory bus between `mips_cpu_bus` and `ram_tiny_CPU`. Master 0 is the CPU; master 1 is a secondary requester, such as a program loader or debug port, that must reach the same RAM without stopping the CPU. The block grants the slave to one master at a time and forwards that master's request to the slave. It holds the other master with waitrequest, applies round-robin with a bounded hold count for fairness, and flags illegal simultaneous read+write.

## Interface
Parameters:
- `MAX_HOLD`, default 4: consecutive completed transactions a master may keep while the other is requesting (≥1).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_address`, `m1_address`  in  32  master byte address.
- `m0_read`, `m1_read`, `m0_write`, `m1_write`  in  1  request strobes.
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes.
- `m0_writedata`, `m1_writedata`  in  32  write data.
- `m0_readdata`, `m1_readdata`  out  32  equals `s_readdata` (broadcast).
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to each master.
- `s_address`  out  32  address to RAM.
- `s_read`, `s_write`  out  1  strobes to RAM.
- `s_byteenable`  out  4  byte lanes to RAM.
- `s_writedata`  out  32  write data to RAM.
- `s_readdata`  in  32  read data from RAM.
- `s_waitrequest`  in  1  stall from RAM.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `protocol_error`  out  1  sticky error flag.

## Operation
- A master "requests" when its read or write strobe is high.
- A transaction completes in the cycle where the owner requests and `s_waitrequest`=0.
- FSM states are IDLE, GRANT0 and GRANT1. Internal state is `last_grant` (1 bit) and `hold_cnt` (width $clog2(MAX_HOLD+1)).
- IDLE:
  - No slave strobes are driven.
  - Both waitrequests are 1.
  - If exactly one master requests, go to that master's GRANT state.
  - If both request, grant the master ≠ `last_grant`.
  - Either way, clear `hold_cnt` on entry.
- GRANTk, slave signals:
  - `s_*` = mk_* combinationally.
  - `mk_waitrequest` = `s_waitrequest`.
  - The other master's waitrequest = 1.
- GRANTk, on completion: `hold_cnt`++ and `last_grant`←k.
- GRANTk, next state, evaluated every cycle in this priority order:
  1. Completion AND `hold_cnt`+1 ≥ MAX_HOLD AND other master requesting → GRANT other, `hold_cnt`←0.
  2. Master k not requesting AND other master requesting → GRANT other, `hold_cnt`←0.
  3. Master k not requesting AND other master idle → IDLE.
  4. Otherwise stay in GRANTk.
- A grant never changes while the owner has an incomplete transaction (strobe high, `s_waitrequest`=1).
- Read+write from the owner in the same cycle:
  - Forward the write only (`s_read`=0).
  - Set `protocol_error`, which stays 1 until reset.
- Requests from a non-owner are ignored and never reach the slave.

## Timing
- Reset values:
  - State IDLE, `grant`=00, `last_grant`=1 (so master 0 wins the first tie), `hold_cnt`=0, `protocol_error`=0.
  - `s_read`=`s_write`=0, both waitrequests 1.
  - `s_address`, `s_writedata`, `s_byteenable` = 0 in IDLE.
- Grant latency: a request seen in IDLE at edge N is forwarded to the slave in cycle N+1. The minimum access is 2 cycles from IDLE.
- Back-to-back accesses by the current owner add zero bubble cycles.
- Switching owners costs no idle cycle: the new owner is forwarded the cycle after the decision edge.
- Reset asserted mid-transaction aborts it. Next cycle all outputs hold reset values; the slave sees strobes drop, and the master must reissue.
- `readdata` is combinational, valid in the completion cycle.

## Structure
- Shared package `mem_bus_pkg`: `arb_state_t` enum (IDLE, GRANT0, GRANT1), `MASTER_CPU`=0, `MASTER_AUX`=1.
- No sub-module is needed: one module with a registered FSM plus a combinational forwarding mux.

## Test plan
- **Single master:** reset; m0 reads 0xBFC00000 with 0 slave wait states.
  - `grant`=01 one cycle after the request.
  - `m0_waitrequest` drops in that cycle, and `m1_waitrequest` stays 1.
- **Tie-break:** m0 and m1 request in the same cycle right after reset.
  - GRANT0 first.
  - After m0 drops its request, GRANT1 follows with no IDLE cycle.
- **Fairness:** MAX_HOLD=4; m0 issues continuous reads while m1 requests a write of 0xDEADBEEF, byteenable 1111.
  - Exactly 4 m0 completions occur, then `grant`=10.
  - The slave sees `s_write`=1 with m1's data.
- **Slave stall:** `s_waitrequest` held 1 for 3 cycles during an m1 write while m0 requests.
  - The grant stays 10 until completion.
  - m0 is never forwarded during the stall.
- **Error:** the owner drives read=write=1.
  - `s_read`=0, `s_write`=1.
  - `protocol_error`=1 and persists until reset.
- **Reset abort:** `reset` pulsed while the owner is waiting.
  - Next cycle `grant`=00, strobes are 0, both waitrequests are 1.
